// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) with start/busy/done handshake.
// Define BIN2BCD_BLANK_EN to add the leading-zero blanking output `blank`.
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    bin_in,
  input  logic                overflow_in,
  input  logic                start,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                overflow,
  output logic                busy,
  output logic                done
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]   blank
`endif
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_load;
  logic            w_shift;
  logic            w_commit;

  logic [WIDTH-1:0] r_sr;
  logic [BW-1:0]    r_scratch;
  logic [CW-1:0]    r_cnt;
  logic             r_pend;
  logic [BW-1:0]    r_bcd;
  logic             r_ovf;
  logic             r_done;
  logic [BW-1:0]    w_adj;
  logic [BW-1:0]    w_shifted;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

  function automatic logic [BW-1:0] adjust(input logic [BW-1:0] s);
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = add3(s[4*i +: 4]);
    end
    return r;
  endfunction

  // Correct every digit before the shift so a carry into the next digit lands as decimal.
  always_comb begin
    w_adj     = adjust(r_scratch);
    w_shifted = {w_adj[BW-2:0], r_sr[WIDTH-1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_shift  = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == CW'(1)) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_commit = 1'b1;
        w_next   = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] r_blank;
  logic [DIGITS-1:0] w_blank;
  logic              w_zrun;

  // A digit blanks only if it and every digit above it are zero; units always shown.
  always_comb begin
    w_blank = '0;
    w_zrun  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_zrun     = w_zrun & (r_scratch[4*i +: 4] == 4'd0);
      w_blank[i] = w_zrun;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_blank <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else if (w_commit) begin
      r_blank <= w_blank;
    end
  end

  assign blank = r_blank;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr      <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_pend    <= 1'b0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_load) begin
        r_sr      <= bin_in;
        r_pend    <= overflow_in;
        r_scratch <= '0;
        r_cnt     <= CW'(WIDTH);
      end
      if (w_shift) begin
        r_scratch <= w_shifted;
        r_sr      <= {r_sr[WIDTH-2:0], 1'b0};
        r_cnt     <= r_cnt - CW'(1);
      end
      if (w_commit) begin
        r_bcd <= r_scratch;
        r_ovf <= r_pend;
      end
    end
  end

  assign bcd_out  = r_bcd;
  assign overflow = r_ovf;
  assign done     = r_done;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed testbench for bin2bcd_seq: latency, handshake, ignored starts, reset abort, free-running refresh.
module tb_bin2bcd_seq;

  logic        clk;
  logic        reset;
  logic [15:0] bin_in;
  logic        overflow_in;
  logic        start;
  logic [19:0] bcd_out;
  logic        overflow;
  logic        busy;
  logic        done;
`ifdef BIN2BCD_BLANK_EN
  logic [4:0]  blank;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .bin_in      (bin_in),
    .overflow_in (overflow_in),
    .start       (start),
    .bcd_out     (bcd_out),
    .overflow    (overflow),
    .busy        (busy),
    .done        (done)
`ifdef BIN2BCD_BLANK_EN
    ,
    .blank       (blank)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pulse start for one edge; returns at the negedge just after the accepting edge.
  task automatic start_conv(input logic [15:0] v, input logic ov);
    @(negedge clk);
    bin_in      = v;
    overflow_in = ov;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Cycles from the accepting edge until done is seen (-1 on timeout) and busy samples on the way.
  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      cyc++;
    end
    if (!done) cyc = -1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; bin_in = '0; overflow_in = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bcd_out !== 20'h00000 || overflow !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: bcd=%h ovf=%b busy=%b done=%b, want 00000/0/0/0", bcd_out, overflow, busy, done);
    end
`ifdef BIN2BCD_BLANK_EN
    n_cmp++;
    if (blank !== 5'b11110) begin
      n_fail++;
      $display("FAIL reset_blank: got %b want 11110", blank);
    end
`endif
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero;
    int cyc, bcnt;
    start_conv(16'h0000, 1'b0);
    wait_done(cyc, bcnt);
    n_cmp++;
    if (cyc !== 17) begin
      n_fail++;
      $display("FAIL zero_latency: got %0d want 17", cyc);
    end
    n_cmp++;
    if (bcd_out !== 20'h00000 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_value: bcd=%h ovf=%b want 00000/0", bcd_out, overflow);
    end
`ifdef BIN2BCD_BLANK_EN
    n_cmp++;
    if (blank !== 5'b11110) begin
      n_fail++;
      $display("FAIL zero_blank: got %b want 11110", blank);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_fib;
    int cyc, bcnt;
    start_conv(16'h1A6D, 1'b0);
    n_cmp++;
    if (bcd_out !== 20'h00000) begin
      n_fail++;
      $display("FAIL fib_no_early_update: bcd=%h want 00000", bcd_out);
    end
    wait_done(cyc, bcnt);
    n_cmp++;
    if (cyc !== 17 || bcnt !== 17) begin
      n_fail++;
      $display("FAIL fib_timing: latency=%0d busy_cycles=%0d want 17/17", cyc, bcnt);
    end
    n_cmp++;
    if (bcd_out !== 20'h06765) begin
      n_fail++;
      $display("FAIL fib_value: got %h want 06765", bcd_out);
    end
`ifdef BIN2BCD_BLANK_EN
    n_cmp++;
    if (blank !== 5'b10000) begin
      n_fail++;
      $display("FAIL fib_blank: got %b want 10000", blank);
    end
`endif
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || bcd_out !== 20'h06765) begin
      n_fail++;
      $display("FAIL fib_done_pulse: done=%b busy=%b bcd=%h want 0/0/06765", done, busy, bcd_out);
    end
  endtask

  task automatic test_max_then_small;
    int cyc, bcnt;
    start_conv(16'hFFFF, 1'b1);
    wait_done(cyc, bcnt);
    n_cmp++;
    if (cyc !== 17 || bcd_out !== 20'h65535 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL max_value: lat=%0d bcd=%h ovf=%b want 17/65535/1", cyc, bcd_out, overflow);
    end
    @(negedge clk);
    start_conv(16'h0059, 1'b0);
    wait_done(cyc, bcnt);
    n_cmp++;
    if (cyc !== 17 || bcd_out !== 20'h00089 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL small_value: lat=%0d bcd=%h ovf=%b want 17/00089/0", cyc, bcd_out, overflow);
    end
`ifdef BIN2BCD_BLANK_EN
    n_cmp++;
    if (blank !== 5'b11100) begin
      n_fail++;
      $display("FAIL small_blank: got %b want 11100", blank);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int cyc, extra;
    start_conv(16'h0037, 1'b0);
    cyc = 0;
    repeat (4) begin
      @(negedge clk);
      cyc++;
    end
    bin_in      = 16'h0090;
    overflow_in = 1'b1;
    start       = 1'b1;
    @(negedge clk);
    cyc++;
    start = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (cyc !== 17 || bcd_out !== 20'h00055 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_value: lat=%0d bcd=%h ovf=%b want 17/00055/0", cyc, bcd_out, overflow);
    end
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) extra++;
    end
    n_cmp++;
    if (extra !== 0 || bcd_out !== 20'h00055) begin
      n_fail++;
      $display("FAIL ignore_no_second_done: extra_done=%0d bcd=%h want 0/00055", extra, bcd_out);
    end
  endtask

  task automatic test_reset_abort;
    int cyc, bcnt, extra;
    start_conv(16'h2AC2, 1'b0);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bcd_out !== 20'h00000 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_reset: bcd=%h busy=%b done=%b want 00000/0/0", bcd_out, busy, done);
    end
    reset = 1'b0;
    extra = 0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done: active_cycles=%0d want 0", extra);
    end
    start_conv(16'h2AC2, 1'b0);
    wait_done(cyc, bcnt);
    n_cmp++;
    if (cyc !== 17 || bcd_out !== 20'h10946) begin
      n_fail++;
      $display("FAIL abort_restart: lat=%0d bcd=%h want 17/10946", cyc, bcd_out);
    end
`ifdef BIN2BCD_BLANK_EN
    n_cmp++;
    if (blank !== 5'b00000) begin
      n_fail++;
      $display("FAIL restart_blank: got %b want 00000", blank);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int cyc, bcnt, gap, bad;
    @(negedge clk);
    bin_in      = 16'h0015;
    overflow_in = 1'b0;
    start       = 1'b1;
    @(negedge clk);
    wait_done(cyc, bcnt);
    n_cmp++;
    if (cyc !== 17 || bcd_out !== 20'h00021) begin
      n_fail++;
      $display("FAIL freerun_first: lat=%0d bcd=%h want 17/00021", cyc, bcd_out);
    end
    bad = 0;
    for (int p = 0; p < 3; p++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
        if (bcd_out !== 20'h00021) bad++;
      end while (!done && gap < 40);
      n_cmp++;
      if (gap !== 18) begin
        n_fail++;
        $display("FAIL freerun_period%0d: got %0d want 18", p, gap);
      end
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL freerun_stable: unstable_samples=%0d want 0", bad);
    end
    start = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; bin_in = '0; overflow_in = 1'b0;
    test_reset;
    test_zero;
    test_fib;
    test_max_then_small;
    test_ignore_start;
    test_reset_abort;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
